// File: rtl/famicom_pad_serializer.sv
// Multi-pad Famicom/NES/SNES serial responder: synchronises the core's latch and
// shift clock, keeps one shift register per pad and presents bit0 of each pad
// on its own serial data line.

// Per-pad shift register plus registered serial output.
module famicom_pad_lane #(
    parameter int PAD_BITS        = 8,
    parameter int FILL_BIT        = 1,
    parameter int ACTIVE_LOW_DATA = 1
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                load,
    input  logic                shift,
    input  logic [PAD_BITS-1:0] load_val,
    output logic                data
);
    // Level driven for a logical 0 (released) button.
    localparam logic REL_LVL = (ACTIVE_LOW_DATA != 0);

    logic [PAD_BITS-1:0] sr_q, sr_d;
    logic                data_q, data_d;

    // Load wins over shift; the output flop takes the new bit0 in the same cycle
    // the register changes, so no extra cycle is added to the pin-to-data latency.
    always_comb begin
        sr_d = sr_q;
        if (load)
            sr_d = load_val;
        else if (shift)
            sr_d = {1'(FILL_BIT), sr_q[PAD_BITS-1:1]};
        data_d = sr_d[0] ^ REL_LVL;
    end

    // Shift register and output flop.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            data_q <= REL_LVL;
        end else begin
            sr_q   <= sr_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;
endmodule

module famicom_pad_serializer #(
    parameter int NUM_PADS        = 2,
    parameter int PAD_BITS        = 8,
    parameter int FILL_BIT        = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW_DATA = 1,
    localparam int CW             = $clog2(PAD_BITS + 1)
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [NUM_PADS*PAD_BITS-1:0] pad_buttons,
    input  logic [PAD_BITS-1:0]          kbd_bits,
    input  logic                         kbd_valid,
    input  logic                         famicom_latch,
    input  logic                         famicom_pulse,
    output logic [NUM_PADS-1:0]          famicom_data,
    output logic [CW-1:0]                bit_count,
    output logic                         frame_done
);
    localparam logic [CW-1:0] BC_MAX  = CW'(PAD_BITS);
    localparam logic [CW-1:0] BC_LAST = CW'(PAD_BITS - 1);

    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES-1:0] pulse_sync_q, pulse_sync_d;
    logic                   pulse_prev_q, pulse_prev_d;
    logic [CW-1:0]          bc_q, bc_d;
    logic                   fd_q, fd_d;

    logic                   latch_s, pulse_s, pulse_rise, do_shift;
    logic [NUM_PADS-1:0][PAD_BITS-1:0] load_val;

    assign latch_s = latch_sync_q[SYNC_STAGES-1];
    assign pulse_s = pulse_sync_q[SYNC_STAGES-1];

    // Synchroniser chains; the extra pulse copy feeds the rising-edge detector.
    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], famicom_latch};
        pulse_sync_d = {pulse_sync_q[SYNC_STAGES-2:0], famicom_pulse};
        pulse_prev_d = pulse_s;
    end

    // Shared frame control: LOAD while latched, count shifts until exhausted.
    always_comb begin
        pulse_rise = pulse_s & ~pulse_prev_q;
        do_shift   = ~latch_s & pulse_rise;
        bc_d       = bc_q;
        fd_d       = 1'b0;
        if (latch_s) begin
            bc_d = '0;
        end else if (pulse_rise && bc_q != BC_MAX) begin
            bc_d = bc_q + 1'b1;
            fd_d = (bc_q == BC_LAST);
        end
    end

    // Keyboard bitmap merges into pad 0 only.
    always_comb begin
        for (int p = 0; p < NUM_PADS; p++)
            load_val[p] = pad_buttons[p*PAD_BITS +: PAD_BITS];
        if (kbd_valid)
            load_val[0] = load_val[0] | kbd_bits;
    end

    // Control and synchroniser state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            pulse_prev_q <= 1'b0;
            bc_q         <= BC_MAX;
            fd_q         <= 1'b0;
        end else begin
            latch_sync_q <= latch_sync_d;
            pulse_sync_q <= pulse_sync_d;
            pulse_prev_q <= pulse_prev_d;
            bc_q         <= bc_d;
            fd_q         <= fd_d;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
        famicom_pad_lane #(
            .PAD_BITS       (PAD_BITS),
            .FILL_BIT       (FILL_BIT),
            .ACTIVE_LOW_DATA(ACTIVE_LOW_DATA)
        ) u_lane (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .load    (latch_s),
            .shift   (do_shift),
            .load_val(load_val[p]),
            .data    (famicom_data[p])
        );
    end

    assign bit_count  = bc_q;
    assign frame_done = fd_q;
endmodule
